// File: rtl/or_stim_pkg.sv
// Shared types and constants for the OR-stage stimulus generator.
// The LFSR constants and helper are only referenced when OR_STIM_LFSR_EN is defined.
package or_stim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Right-shifting Galois step for x^8+x^6+x^5+x^4+1
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    lfsr_next = (s >> 1) ^ (s[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/or_stim_lfsr.sv
// 8-bit Galois LFSR: load restores the seed, step advances one state.
// Only instantiated when OR_STIM_LFSR_EN is defined.
module or_stim_lfsr
  import or_stim_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  output logic [7:0] q
);

  logic [7:0] q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else if (load) begin
      q_q <= LFSR_SEED;
    end else if (step) begin
      q_q <= lfsr_next(q_q);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/or_stim_gen.sv
// Clocked, restartable walking-toggle stimulus for the four-input OR stage.
// Optional feature: define OR_STIM_LFSR_EN to add lfsr_mode and an LFSR-driven pattern.
module or_stim_gen
  import or_stim_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50,
  parameter int unsigned STEPS    = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
`ifdef OR_STIM_LFSR_EN
  input  logic lfsr_mode,
`endif
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic tick,
  output logic busy,
  output logic done
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned KW = $clog2(STEPS + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(STEPS - 1);

  state_e        state_q;
  logic [PW-1:0] pre_q;
  logic [KW-1:0] k_q;
  logic          ph_b_q, ph_b_d;
  logic [1:0]    ph_c_q, ph_c_d;
  logic [1:0]    ph_d_q, ph_d_d;
  logic [3:0]    tog_q, tog_d;
  logic [3:0]    abcd_q, abcd_d;
  logic          tick_q, busy_q, done_q;
  logic          wrap, go_run;

  assign wrap   = (pre_q == PRE_LAST);
  assign go_run = start && !stop && (state_q != RUN);

`ifdef OR_STIM_LFSR_EN
  logic       lfsr_mode_q;
  logic [7:0] lfsr_q;
  logic [7:0] lfsr_nx;

  // The pattern shown at a tick is the state the LFSR advances into on that edge
  assign lfsr_nx = lfsr_next(lfsr_q);

  or_stim_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (go_run),
    .step ((state_q == RUN) && wrap && !stop),
    .q    (lfsr_q)
  );
`endif

  // Phase counters mod 1..4; a channel toggles when its phase counter wraps
  always_comb begin
    ph_b_d = ~ph_b_q;
    ph_c_d = (ph_c_q == 2'd2) ? 2'd0 : ph_c_q + 2'd1;
    ph_d_d = ph_d_q + 2'd1;
    tog_d  = tog_q ^ {1'b1, ph_b_q, (ph_c_q == 2'd2), (ph_d_q == 2'd3)};
    abcd_d = tog_d;
`ifdef OR_STIM_LFSR_EN
    if (lfsr_mode_q) abcd_d = lfsr_nx[3:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      k_q     <= '0;
      ph_b_q  <= 1'b0;
      ph_c_q  <= '0;
      ph_d_q  <= '0;
      tog_q   <= '0;
      abcd_q  <= '0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef OR_STIM_LFSR_EN
      lfsr_mode_q <= 1'b0;
`endif
    end else begin
      tick_q <= 1'b0;
      if (stop || go_run) begin
        // stop has priority; both paths clear the run state, only go_run enters RUN
        state_q <= stop ? IDLE : RUN;
        busy_q  <= !stop;
        done_q  <= 1'b0;
        pre_q   <= '0;
        k_q     <= '0;
        ph_b_q  <= 1'b0;
        ph_c_q  <= '0;
        ph_d_q  <= '0;
        tog_q   <= '0;
        abcd_q  <= '0;
`ifdef OR_STIM_LFSR_EN
        if (!stop) lfsr_mode_q <= lfsr_mode;
`endif
      end else if (state_q == RUN) begin
        if (wrap) begin
          pre_q  <= '0;
          k_q    <= k_q + 1'b1;
          ph_b_q <= ph_b_d;
          ph_c_q <= ph_c_d;
          ph_d_q <= ph_d_d;
          tog_q  <= tog_d;
          abcd_q <= abcd_d;
          tick_q <= 1'b1;
          if (k_q == K_LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end else begin
          pre_q <= pre_q + 1'b1;
        end
      end
    end
  end

  assign {a, b, c, d} = abcd_q;
  assign tick         = tick_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
